// File: rtl/reg_file_2r1w_if.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w_if
//   Bus bundle between the decode/write-back logic and the 2R1W register file.
//
//   Signals:
//     rd_addr1 / rd_addr2 : read port addresses (instruction rs / rt)
//     rd_data1 / rd_data2 : read port data
//     wr_addr             : write address from the destination-register selector
//     wr_data             : write-back value
//     wr_en               : write enable (RegWrite)
//
//   Modports:
//     master : datapath side, drives addresses and write data, receives read data
//     slave  : register-file side
// ---------------------------------------------------------------------------
interface reg_file_2r1w_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;

    modport master (
        output rd_addr1, rd_addr2, wr_addr, wr_data, wr_en,
        input  rd_data1, rd_data2
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_addr, wr_data, wr_en,
        output rd_data1, rd_data2
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// reg_file_2r1w
//   Two-read, one-write general-purpose register file for the MIPS datapath.
//   Register 0 has no storage and always reads 0. Writes to address 0 are
//   dropped. With BYPASS=1 a read of the address being written in the same
//   cycle returns wr_data combinationally, so decode sees write-back data
//   without a stall.
//
//   Parameters:
//     DATA_W : register width in bits
//     ADDR_W : address width, depth = 2**ADDR_W
//     BYPASS : 1 = same-cycle write-through forwarding, 0 = stored value only
//
//   Ports:
//     clk   : rising-edge clock for all state
//     rst_n : asynchronous active-low reset, clears every register
//     bus   : reg_file_2r1w_if slave modport (read/write ports); its
//             DATA_W/ADDR_W must match this module's parameters
// ---------------------------------------------------------------------------
module reg_file_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_file_2r1w_if.slave        bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 is hard-wired to zero, so storage starts at index 1.
    logic [DATA_W-1:0] mem_q [1:DEPTH-1];
    logic [DATA_W-1:0] mem_d [1:DEPTH-1];

    logic              wr_hit;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    // A write is only real when it targets a stored register.
    assign wr_hit = bus.wr_en && (bus.wr_addr != '0);

    // Next-state: each entry either keeps its value or takes wr_data.
    // NOTE: every output of an always_comb is given a value on every path
    // (here the hold value first), otherwise synthesis infers a latch.
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_hit && (bus.wr_addr == ADDR_W'(i))) begin
                mem_d[i] = bus.wr_data;
            end
        end
    end

    // NOTE: this array is reset on purpose -- the register file must read 0
    // from reset onwards, so it maps to flops with async clear rather than a
    // RAM macro (RAMs cannot be cleared this way).
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its d-input from before the edge, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read ports. Forwarding is suppressed while reset is asserted so the
    // ports read 0 for the whole reset window, matching the cleared storage.
    always_comb begin
        rd_data1 = '0;
        if (bus.rd_addr1 != '0) begin
            if (BYPASS && rst_n && wr_hit && (bus.rd_addr1 == bus.wr_addr)) begin
                rd_data1 = bus.wr_data;
            end else begin
                rd_data1 = mem_q[bus.rd_addr1];
            end
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (bus.rd_addr2 != '0) begin
            if (BYPASS && rst_n && wr_hit && (bus.rd_addr2 == bus.wr_addr)) begin
                rd_data2 = bus.wr_data;
            end else begin
                rd_data2 = mem_q[bus.rd_addr2];
            end
        end
    end

    assign bus.rd_data1 = rd_data1;
    assign bus.rd_data2 = rd_data2;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// ---------------------------------------------------------------------------
// tb_reg_file_2r1w
//   Drives identical stimulus into a BYPASS=1 and a BYPASS=0 instance. Each
//   sample point pushes the hand-computed expected read data for both
//   instances into a queue; a separate monitor pops and compares when the
//   sample strobe fires.
// ---------------------------------------------------------------------------
module tb_reg_file_2r1w;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst_n;

    reg_file_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b1 ();
    reg_file_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b0 ();

    reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) dut_b1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b1.slave)
    );

    reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) dut_b0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b0.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] b1_p1;
        logic [31:0] b1_p2;
        logic [31:0] b0_p1;
        logic [31:0] b0_p2;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input string port,
                         input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s: got %h want %h", name, port, got, want);
        end
    endtask

    // Monitor: compares every queued expectation when the strobe fires.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, "bypass1.rd_data1", bus_b1.rd_data1, e.b1_p1);
                check(e.name, "bypass1.rd_data2", bus_b1.rd_data2, e.b1_p2);
                check(e.name, "bypass0.rd_data1", bus_b0.rd_data1, e.b0_p1);
                check(e.name, "bypass0.rd_data2", bus_b0.rd_data2, e.b0_p2);
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        bus_b1.wr_en = we;  bus_b0.wr_en = we;
        bus_b1.wr_addr = wa; bus_b0.wr_addr = wa;
        bus_b1.wr_data = wd; bus_b0.wr_data = wd;
        bus_b1.rd_addr1 = a1; bus_b0.rd_addr1 = a1;
        bus_b1.rd_addr2 = a2; bus_b0.rd_addr2 = a2;
    endtask

    task automatic expect_rd(input string name,
                             input logic [31:0] b1_p1, input logic [31:0] b1_p2,
                             input logic [31:0] b0_p1, input logic [31:0] b0_p2);
        exp_t e;
        e.name = name;
        e.b1_p1 = b1_p1; e.b1_p2 = b1_p2;
        e.b0_p1 = b0_p1; e.b0_p2 = b0_p2;
        sb.push_back(e);
        -> sample_ev;
        #1;
    endtask

    function automatic logic [31:0] sweep_val(input int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
    endfunction

    initial begin
        logic [31:0] seq_val [3];
        seq_val[0] = 32'hAAAA_0001;
        seq_val[1] = 32'hBBBB_0002;
        seq_val[2] = 32'hCCCC_0003;

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
        #1 expect_rd("reset_state", 0, 0, 0, 0);

        // Reset clears r5 asynchronously, mid-cycle.
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        #1 expect_rd("r5_write_cycle", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
        @(negedge clk);
        drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
        #1 expect_rd("r5_stored", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1 expect_rd("r5_async_clear", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 expect_rd("r5_after_release", 0, 0, 0, 0);
        @(negedge clk);
        #1 expect_rd("r5_after_release_clk", 0, 0, 0, 0);

        // Register 0 ignores writes and reads 0.
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1 expect_rd("r0_during_write", 0, 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1 expect_rd("r0_after_write", 0, 0, 0, 0);

        // Full sweep: write r1..r31, read pairs (i, 32-i).
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), sweep_val(i), 5'd0, 5'd0);
        end
        for (int i = 0; i < 32; i++) begin
            int j;
            j = (32 - i) % 32;
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(j));
            #1 expect_rd($sformatf("sweep_%0d_%0d", i, j),
                         sweep_val(i), sweep_val(j), sweep_val(i), sweep_val(j));
        end

        // Forwarding vs no forwarding on r7.
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7);
        #1 expect_rd("fwd_before_edge", 32'h2222_2222, 32'h2222_2222,
                     32'h1111_1111, 32'h1111_1111);
        @(negedge clk);
        drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
        #1 expect_rd("fwd_after_edge", 32'h2222_2222, 32'h2222_2222,
                     32'h2222_2222, 32'h2222_2222);

        // Forwarding only on the port whose address matches.
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h3333_3333, 5'd7, 5'd8);
        #1 expect_rd("fwd_one_port", 32'h3333_3333, sweep_val(8),
                     32'h2222_2222, sweep_val(8));

        // Back-to-back writes to r3: each value visible for one cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 5'd3, seq_val[k], 5'd3, 5'd3);
            #1 expect_rd($sformatf("b2b_write_%0d", k), seq_val[k], seq_val[k],
                         (k == 0) ? sweep_val(3) : seq_val[k-1],
                         (k == 0) ? sweep_val(3) : seq_val[k-1]);
        end
        @(negedge clk);
        drive(1'b0, 5'd3, 32'h0, 5'd3, 5'd3);
        #1 expect_rd("b2b_last_wins", seq_val[2], seq_val[2], seq_val[2], seq_val[2]);

        // Reset again, then write-disabled cycle must leave r9 at 0.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
        #1 expect_rd("reset_again", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 5'd9, 32'hABCD_0123, 5'd9, 5'd9);
        #1 expect_rd("wr_dis_before", 0, 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        #1 expect_rd("wr_dis_after", 0, 0, 0, 0);

        // Reset asserted during a write cycle: reset wins.
        @(negedge clk);
        drive(1'b1, 5'd9, 32'hABCD_0123, 5'd9, 5'd9);
        #1 expect_rd("r9_write_pre_reset", 32'hABCD_0123, 32'hABCD_0123, 0, 0);
        rst_n = 1'b0;
        #1 expect_rd("r9_write_in_reset", 0, 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        rst_n = 1'b1;
        #1 expect_rd("r9_after_reset_write", 0, 0, 0, 0);
        @(negedge clk);
        #1 expect_rd("r9_after_reset_clk", 0, 0, 0, 0);

        // Bounded drain of the scoreboard.
        for (int t = 0; t < 10 && sb.size() > 0; t++) #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got no sample want compare", e.name);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
